// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: MULT/MULTU in one cycle, DIV/DIVU by 32-step restoring
// division, MTHI/MTLO moves. Define HILO_DIV_FAST_PATH_EN to shortcut trivial divides.
module hilo_muldiv #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DIV_FIX
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // opa: multiplicand, or dividend shifting out while quotient bits shift in
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [31:0]      rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;

    logic             is_mul, is_div;
    logic [31:0]      abs1, abs2;
    logic [63:0]      mul_a, mul_b, product;
    logic [32:0]      rem_shift;
    logic [31:0]      rem_sub;
    logic             sub_ok;
    logic [31:0]      quo_fix, rem_fix;

    // Datapath helpers shared by the FSM below.
    always_comb begin
        is_mul    = (op == 4'b0001) || (op == 4'b0010);
        is_div    = (op == 4'b0100) || (op == 4'b1000);
        abs1      = (op[2] && src1[31]) ? -src1 : src1;
        abs2      = (op[2] && src2[31]) ? -src2 : src2;
        mul_a     = {{32{sgn_q & opa_q[31]}}, opa_q};
        mul_b     = {{32{sgn_q & opb_q[31]}}, opb_q};
        product   = mul_a * mul_b;
        rem_shift = {rem_q, opa_q[31]};
        sub_ok    = (rem_shift >= {1'b0, opb_q});
        // The true difference is below the divisor, so 32 bits cannot overflow.
        rem_sub   = rem_shift[31:0] - opb_q;
        quo_fix   = neg_quo_q ? -opa_q : opa_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && is_mul) begin
                    opa_d   = src1;
                    opb_d   = src2;
                    sgn_d   = op[0];
                    state_d = ST_MUL;
                end else if (start && is_div) begin
                    opa_d     = abs1;
                    opb_d     = abs2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = op[2] & (src1[31] ^ src2[31]);
                    neg_rem_d = op[2] & src1[31];
                    div0_d    = (src2 == 32'h0);
                    state_d   = ST_DIV;
`ifdef HILO_DIV_FAST_PATH_EN
                    // Quotient is zero (or overridden for /0) and remainder is the dividend.
                    if ((src2 == 32'h0) || (abs1 < abs2)) begin
                        opa_d   = '0;
                        rem_d   = abs1;
                        state_d = ST_DIV_FIX;
                    end
`endif
                end
            end
            ST_MUL: begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_DIV: begin
                opa_d = {opa_q[30:0], sub_ok};
                rem_d = sub_ok ? rem_sub : rem_shift[31:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                // Divide by zero: restoring division already leaves |src1| in the remainder.
                hi_d    = rem_fix;
                lo_d    = div0_q ? 32'hFFFF_FFFF : quo_fix;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; working regs are
    // reset too so a discarded operation leaves no stale operands behind.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: randomized mul/div against an arithmetic
// reference model, plus directed moves, flush, reset and back-to-back scenarios.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        resetn, start, mthi, mtlo, flush;
    logic [3:0]  op;
    logic [31:0] src1, src2, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        case (o)
            4'b0001: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            4'b0010: return {32'h0, a} * {32'h0, b};
            4'b0100: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'b1000: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[0] | o[1]) return 1;
`ifdef HILO_DIV_FAST_PATH_EN
        if (b == 32'h0 || mag(a, o[2]) < mag(b, o[2])) return 1;
`endif
        return 33;
    endfunction

    // Launches one op, counts busy cycles (bounded), samples results and the done pulse.
    task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] hv, output logic [31:0] lv,
                          output logic dv, output logic dn);
        op = o; src1 = a; src2 = b; start = 1'b1;
        tick();
        start = 1'b0; op = 4'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        hv = hi; lv = lo; dv = done;
        tick();
        dn = done;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        total++; if (hi !== 32'h0)   begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0)   begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [3:0]  o;
        logic [31:0] a, b, hv, lv;
        logic [63:0] exp;
        logic        dv, dn;
        int          cyc;
        for (int i = 0; i < 14; i++) begin
            if (i < 2) begin
                o = (i == 0) ? 4'b0001 : 4'b0010;
                a = 32'hFFFF_FFFF; b = 32'h2;
            end else begin
                o = ($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0010;
                a = $urandom; b = $urandom >> $urandom_range(0, 31);
                if (i == 2) a = 32'h8000_0000;
                if (i == 3) b = 32'h0;
            end
            exp = model(o, a, b);
            launch(o, a, b, cyc, hv, lv, dv, dn);
            total++; if (cyc !== exp_cycles(o, a, b)) begin bad++; $display("FAIL mult%0d busy_cycles got=%0d exp=%0d", i, cyc, exp_cycles(o, a, b)); end
            total++; if ({hv, lv} !== exp) begin bad++; $display("FAIL mult%0d op=%b a=%h b=%h hilo got=%h exp=%h", i, o, a, b, {hv, lv}, exp); end
            total++; if (dv !== 1'b1) begin bad++; $display("FAIL mult%0d done_pulse got=%b exp=1", i, dv); end
            total++; if (dn !== 1'b0) begin bad++; $display("FAIL mult%0d done_drop got=%b exp=0", i, dn); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  d_op [8];
        logic [31:0] d_a  [8];
        logic [31:0] d_b  [8];
        logic [3:0]  o;
        logic [31:0] a, b, hv, lv;
        logic [63:0] exp;
        logic        dv, dn;
        int          cyc;
        d_op = '{4'b0100, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100};
        d_a  = '{32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFFB, 32'h8000_0000, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
        d_b  = '{32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'd1, 32'h8000_0000};
        for (int i = 0; i < 18; i++) begin
            if (i < 8) begin
                o = d_op[i]; a = d_a[i]; b = d_b[i];
            end else begin
                o = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b1000;
                a = $urandom >> $urandom_range(0, 16);
                b = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 5) == 0) b = 32'h0;
            end
            exp = model(o, a, b);
            launch(o, a, b, cyc, hv, lv, dv, dn);
            total++; if (cyc !== exp_cycles(o, a, b)) begin bad++; $display("FAIL div%0d busy_cycles got=%0d exp=%0d", i, cyc, exp_cycles(o, a, b)); end
            total++; if ({hv, lv} !== exp) begin bad++; $display("FAIL div%0d op=%b a=%h b=%h hilo got=%h exp=%h", i, o, a, b, {hv, lv}, exp); end
            total++; if (dv !== 1'b1) begin bad++; $display("FAIL div%0d done_pulse got=%b exp=1", i, dv); end
            total++; if (dn !== 1'b0) begin bad++; $display("FAIL div%0d done_drop got=%b exp=0", i, dn); end
        end
    endtask

    task automatic test_moves();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        total++; if ({hi, lo} !== {32'hA5A5_5A5A, 32'hA5A5_5A5A}) begin bad++; $display("FAIL move_both got=%h exp=%h", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A}); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL move_done got=%b exp=0", done); end
        mthi = 1'b1; wdata = 32'h1111_2222;
        tick();
        mthi = 1'b0;
        total++; if ({hi, lo} !== {32'h1111_2222, 32'hA5A5_5A5A}) begin bad++; $display("FAIL move_hi got=%h exp=%h", {hi, lo}, {32'h1111_2222, 32'hA5A5_5A5A}); end

        // Non-one-hot and empty op codes are ignored.
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 4'b0011 : 4'b0000; src1 = 32'd9; src2 = 32'd3; start = 1'b1;
            tick();
            start = 1'b0; op = 4'b0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_op%0d busy got=%b exp=0", i, busy); end
            tick();
            total++; if ({hi, lo, done} !== {32'h1111_2222, 32'hA5A5_5A5A, 1'b0}) begin bad++; $display("FAIL bad_op%0d state got=%h exp=%h", i, {hi, lo, done}, {32'h1111_2222, 32'hA5A5_5A5A, 1'b0}); end
        end

        // Move issued together with start lands, then the product overwrites it.
        op = 4'b0010; src1 = 32'd3; src2 = 32'd5; start = 1'b1; mthi = 1'b1; wdata = 32'hBEEF;
        tick();
        start = 1'b0; op = 4'b0; mthi = 1'b0;
        total++; if (hi !== 32'hBEEF) begin bad++; $display("FAIL move_with_start hi got=%h exp=0000beef", hi); end
        tick();
        total++; if ({hi, lo, done} !== {32'h0, 32'd15, 1'b1}) begin bad++; $display("FAIL move_overwrite got=%h exp=%h", {hi, lo, done}, {32'h0, 32'd15, 1'b1}); end
        tick();
    endtask

    task automatic test_flush();
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_0001;
        tick();
        mthi = 1'b0; mtlo = 1'b0;

        op = 4'b1000; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; op = 4'b0;
        for (int i = 0; i < 9; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre busy got=%b exp=1", busy); end
        // Moves while busy are dropped; the flush below then exposes the untouched value.
        mthi = 1'b1; wdata = 32'hFFFF_0000;
        tick();
        mthi = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if ({hi, lo} !== {32'hCAFE_0001, 32'hCAFE_0001}) begin bad++; $display("FAIL flush_hilo got=%h exp=%h", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001}); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done_late got=%b exp=0", done); end

        mthi = 1'b1; wdata = 32'h1234;
        tick();
        mthi = 1'b0;
        total++; if ({hi, lo} !== {32'h1234, 32'hCAFE_0001}) begin bad++; $display("FAIL flush_mthi got=%h exp=%h", {hi, lo}, {32'h1234, 32'hCAFE_0001}); end

        // Flush on the completing MUL edge suppresses the write.
        op = 4'b0001; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
        tick();
        start = 1'b0; op = 4'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if ({hi, lo, done, busy} !== {32'h1234, 32'hCAFE_0001, 2'b00}) begin bad++; $display("FAIL flush_mul_end got=%h exp=%h", {hi, lo, done, busy}, {32'h1234, 32'hCAFE_0001, 2'b00}); end

        // Flush together with start: the op never launches.
        op = 4'b0100; src1 = 32'd50; src2 = 32'd5; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; op = 4'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start busy got=%b exp=0", busy); end
        tick();
        total++; if ({hi, lo, done} !== {32'h1234, 32'hCAFE_0001, 1'b0}) begin bad++; $display("FAIL flush_start state got=%h exp=%h", {hi, lo, done}, {32'h1234, 32'hCAFE_0001, 1'b0}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hv, lv;
        logic        dv, dn;
        int          cyc;
        op = 4'b0100; src1 = 32'hFFFF_0000; src2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; op = 4'b0;
        for (int i = 0; i < 5; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        total++; if ({hi, lo, busy, done} !== 66'h0) begin bad++; $display("FAIL reset_mid got=%h exp=0", {hi, lo, busy, done}); end
        tick();
        launch(4'b0010, 32'd6, 32'd7, cyc, hv, lv, dv, dn);
        total++; if ({hv, lv, dv} !== {32'h0, 32'd42, 1'b1}) begin bad++; $display("FAIL reset_recover got=%h exp=%h", {hv, lv, dv}, {32'h0, 32'd42, 1'b1}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        int          cyc;
        for (int i = 0; i < 8; i++) begin
            o = 4'b0001 << $urandom_range(0, 3);
            a = $urandom; b = $urandom >> $urandom_range(0, 31);
            exp = model(o, a, b);
            op = o; src1 = a; src2 = b; start = 1'b1;
            tick();
            start = 1'b0; op = 4'b0;
            cyc = 0;
            while (busy === 1'b1 && cyc < 200) begin
                cyc++;
                tick();
            end
            total++; if (cyc !== exp_cycles(o, a, b)) begin bad++; $display("FAIL b2b%0d busy_cycles got=%0d exp=%0d", i, cyc, exp_cycles(o, a, b)); end
            total++; if ({hi, lo, done} !== {exp, 1'b1}) begin bad++; $display("FAIL b2b%0d op=%b a=%h b=%h got=%h exp=%h", i, o, a, b, {hi, lo, done}, {exp, 1'b1}); end
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; op = 4'b0; src1 = '0; src2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_moves();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
